// File: rtl/shake_pkg.sv
// shake_pkg: shared constants and FSM state encoding for the SHAKE256 serial padder
package shake_pkg;
  localparam int RATE_WIDTH = 1088;
  localparam int RATE_BYTES = RATE_WIDTH / 8;
  localparam int CNT_W = 11;
  localparam logic [7:0] DS_BYTE = 8'h1F;
  localparam logic [7:0] PAD_LAST_BYTE = 8'h80;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_FULL    = 3'd2,
    ST_PAD     = 3'd3,
    ST_LAST    = 3'd4
  } state_e;
endpackage

// File: rtl/shake_serial_padder_if.sv
// shake_serial_padder_if: serial message input and rate-block output bundle
interface shake_serial_padder_if;
  import shake_pkg::*;
  logic start;
  logic enable;
  logic [1:0] serial_in;
  logic serial_end_signal;
  logic serial_ready;
  logic [RATE_WIDTH-1:0] block_out;
  logic block_valid;
  logic block_last;
  logic block_ready;
  logic pad_error;
  logic [2:0] debug_state;
  logic [CNT_W-1:0] debug_bytecount;
  modport master (
    output start, enable, serial_in, serial_end_signal, block_ready,
    input serial_ready, block_out, block_valid, block_last, pad_error, debug_state, debug_bytecount
  );
  modport slave (
    input start, enable, serial_in, serial_end_signal, block_ready,
    output serial_ready, block_out, block_valid, block_last, pad_error, debug_state, debug_bytecount
  );
endinterface

// File: rtl/shake_chunk_packer.sv
// shake_chunk_packer: gathers four MSB-first 2-bit chunks into one byte
module shake_chunk_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] chunk,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       partial
);
  logic [1:0] cnt;
  logic [5:0] sh;
  assign byte_valid = en & (cnt == 2'd3);
  assign byte_data = {sh, chunk};
  assign partial = (cnt + {1'b0, en}) != 2'd0;
  // chunk counter and shift register; clr drops any partial byte
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
      sh <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      sh <= {sh[3:0], chunk};
    end
  end
endmodule

// File: rtl/shake_serial_padder.sv
// shake_serial_padder: packs serial chunks into rate blocks and applies SHAKE padding
module shake_serial_padder
  import shake_pkg::*;
(
  input logic clk,
  input logic reset,
  shake_serial_padder_if.slave bus
);
  localparam int BW = $clog2(RATE_WIDTH);
  state_e state;
  logic [RATE_WIDTH-1:0] block, pad_block;
  logic [CNT_W-1:0] bytecount;
  logic [BW-1:0] base;
  logic end_pending, block_valid, block_last, serial_ready, pad_error;
  logic clr, byte_valid, partial;
  logic [7:0] byte_data;
  assign base = BW'({bytecount, 3'b000});
  assign clr = serial_ready ? bus.serial_end_signal : (state == ST_IDLE) & bus.start;
  shake_chunk_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .en(serial_ready & bus.enable),
    .chunk(bus.serial_in),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .partial(partial)
  );
  // padded image of the current block; both XORs land correctly when they hit the same byte
  always_comb begin
    pad_block = block;
    pad_block[base +: 8] = block[base +: 8] ^ DS_BYTE;
    pad_block[RATE_WIDTH-8 +: 8] = pad_block[RATE_WIDTH-8 +: 8] ^ PAD_LAST_BYTE;
  end
  // control FSM with block register, byte counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      block <= '0;
      bytecount <= '0;
      end_pending <= 1'b0;
      block_valid <= 1'b0;
      block_last <= 1'b0;
      serial_ready <= 1'b0;
      pad_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          state <= ST_COLLECT;
          block <= '0;
          bytecount <= '0;
          end_pending <= 1'b0;
          pad_error <= 1'b0;
          serial_ready <= 1'b1;
        end
        ST_COLLECT: begin
          if (byte_valid) begin
            block[base +: 8] <= byte_data;
            bytecount <= bytecount + CNT_W'(1);
          end
          if (byte_valid && bytecount == CNT_W'(RATE_BYTES - 1)) begin
            state <= ST_FULL;
            end_pending <= bus.serial_end_signal;
            block_valid <= 1'b1;
            serial_ready <= 1'b0;
          end else if (bus.serial_end_signal) begin
            state <= ST_PAD;
            pad_error <= pad_error | partial;
            serial_ready <= 1'b0;
          end
        end
        ST_FULL: if (bus.block_ready) begin
          block <= '0;
          bytecount <= '0;
          block_valid <= 1'b0;
          end_pending <= 1'b0;
          state <= end_pending ? ST_PAD : ST_COLLECT;
          serial_ready <= ~end_pending;
        end
        ST_PAD: begin
          block <= pad_block;
          state <= ST_LAST;
          block_valid <= 1'b1;
          block_last <= 1'b1;
        end
        ST_LAST: if (bus.block_ready) begin
          state <= ST_IDLE;
          block_valid <= 1'b0;
          block_last <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign bus.serial_ready = serial_ready;
  assign bus.block_out = block;
  assign bus.block_valid = block_valid;
  assign bus.block_last = block_last;
  assign bus.pad_error = pad_error;
  assign bus.debug_state = state;
  assign bus.debug_bytecount = bytecount;
endmodule

// File: tb/tb_shake_serial_padder.sv
// tb_shake_serial_padder: directed vectors against a block-level padding model
module tb_shake_serial_padder;
  localparam int NB = 136;
  typedef struct {
    logic [NB*8-1:0] d;
    logic last;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;
  logic [7:0] msg[$];
  logic [NB*8-1:0] last_blk, hold_d;
  logic hold_l, stalled = 1'b0;
  shake_serial_padder_if bus();
  shake_serial_padder dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [NB*8-1:0] act, input logic [NB*8-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < NB; i++)
        if (act[8*i +: 8] !== exp[8*i +: 8]) begin
          $display("FAIL %s byte[%0d] got %h want %h", name, i, act[8*i +: 8], exp[8*i +: 8]);
          break;
        end
    end
  endtask

  // expected blocks straight from the padding rule: whole rate blocks, then remainder + 1F..80
  task automatic build_exp();
    exp_t x;
    int nfull = msg.size() / NB;
    int r = msg.size() - nfull * NB;
    for (int b = 0; b < nfull; b++) begin
      x.d = '0;
      x.last = 1'b0;
      for (int i = 0; i < NB; i++) x.d[8*i +: 8] = msg[b*NB + i];
      q.push_back(x);
    end
    x.d = '0;
    x.last = 1'b1;
    for (int i = 0; i < r; i++) x.d[8*i +: 8] = msg[nfull*NB + i];
    x.d[8*r +: 8] = x.d[8*r +: 8] ^ 8'h1F;
    x.d[8*(NB-1) +: 8] = x.d[8*(NB-1) +: 8] ^ 8'h80;
    q.push_back(x);
  endtask

  // every accepted block is checked against the model; stalled blocks must hold still
  always @(negedge clk) begin
    if (reset) begin
      if (stalled) begin
        chk("stall_valid", bus.block_valid, 1);
        chk_blk("stall_data", bus.block_out, hold_d);
        chk("stall_last", bus.block_last, hold_l);
      end
      if (bus.block_valid && bus.block_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_block", 1, 0);
        end else begin
          e = q.pop_front();
          chk_blk("block", bus.block_out, e.d);
          chk("block_last", bus.block_last, e.last);
          last_blk = bus.block_out;
        end
      end
      stalled = bus.block_valid && !bus.block_ready;
      hold_d = bus.block_out;
      hold_l = bus.block_last;
    end else stalled = 1'b0;
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.serial_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.serial_ready) chk("serial_ready_timeout", 0, 1);
  endtask

  task automatic send_chunk(input logic [1:0] c, input logic with_end);
    wait_ready();
    bus.enable = 1'b1;
    bus.serial_in = c;
    bus.serial_end_signal = with_end;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    bus.serial_end_signal = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_end);
    for (int k = 0; k < 4; k++) send_chunk(b[7-2*k -: 2], with_end && k == 3);
  endtask

  task automatic send_range(input int lo, input int hi, input logic end_last);
    for (int i = lo; i < hi; i++) send_byte(msg[i], end_last && i == hi - 1);
  endtask

  task automatic start_msg();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic end_pulse();
    wait_ready();
    bus.serial_end_signal = 1'b1;
    @(posedge clk); #1;
    bus.serial_end_signal = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || bus.debug_state != 3'd0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_pending_blocks", q.size(), 0);
    chk("done_state_idle", bus.debug_state, 0);
  endtask

  task automatic fill(input int n, input logic [7:0] v);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.enable = 0; bus.serial_in = 0; bus.serial_end_signal = 0; bus.block_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", bus.debug_state, 0);
    chk("rst_valid", bus.block_valid, 0);
    chk("rst_last", bus.block_last, 0);
    chk("rst_sready", bus.serial_ready, 0);
    chk("rst_perr", bus.pad_error, 0);
    chk("rst_blk_zero", bus.block_out == '0, 1);
    chk("rst_count", bus.debug_bytecount, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    // empty message
    msg.delete();
    build_exp();
    start_msg();
    chk("empty_collect", bus.debug_state, 1);
    chk("empty_sready", bus.serial_ready, 1);
    end_pulse();
    wait_done();
    chk("empty_b0", last_blk[7:0], 8'h1F);
    chk("empty_b135", last_blk[8*135 +: 8], 8'h80);
    chk("empty_mid_zero", last_blk[8*135-1:8] == '0, 1);
    chk("empty_perr", bus.pad_error, 0);
    // "abc" with exact end-to-last latency
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    build_exp();
    start_msg();
    send_range(0, 3, 1'b0);
    chk("abc_count", bus.debug_bytecount, 3);
    end_pulse();
    chk("abc_pad_state", bus.debug_state, 3);
    chk("abc_pad_novalid", bus.block_valid, 0);
    @(posedge clk); #1;
    chk("abc_last_valid", bus.block_valid, 1);
    chk("abc_last_flag", bus.block_last, 1);
    wait_done();
    chk("abc_bytes", last_blk[31:0], 32'h1F636261);
    // 135 zero bytes: DS and final pad share the last byte
    fill(135, 8'h00);
    build_exp();
    start_msg();
    send_range(0, 135, 1'b0);
    end_pulse();
    wait_done();
    chk("z135_b135", last_blk[8*135 +: 8], 8'h9F);
    // 136 bytes with separate end, then with end on the final chunk
    for (int m = 0; m < 2; m++) begin
      fill(136, 8'hAA);
      build_exp();
      start_msg();
      send_range(0, 136, m == 1);
      if (m == 0) end_pulse();
      wait_done();
      chk("aa_tail_b0", last_blk[7:0], 8'h1F);
      chk("aa_tail_b135", last_blk[8*135 +: 8], 8'h80);
    end
    // backpressure in FULL with enable held; data resumes after release
    fill(136, 8'hAA);
    msg.push_back(8'h55); msg.push_back(8'h5A); msg.push_back(8'hA5);
    build_exp();
    bus.block_ready = 1'b0;
    start_msg();
    send_range(0, 136, 1'b0);
    chk("bp_full", bus.debug_state, 2);
    for (int i = 0; i < 5; i++) begin
      bus.enable = 1'b1;
      bus.serial_in = 2'b11;
      @(posedge clk); #1;
      chk("bp_sready", bus.serial_ready, 0);
      chk("bp_count", bus.debug_bytecount, 136);
    end
    bus.enable = 1'b0;
    bus.block_ready = 1'b1;
    send_range(136, 139, 1'b0);
    end_pulse();
    wait_done();
    // partial byte at end sets sticky pad_error
    msg.delete();
    msg.push_back(8'h12);
    build_exp();
    start_msg();
    send_byte(8'h12, 1'b0);
    send_chunk(2'b11, 1'b0);
    send_chunk(2'b01, 1'b0);
    end_pulse();
    chk("perr_set", bus.pad_error, 1);
    wait_done();
    chk("perr_sticky", bus.pad_error, 1);
    chk("perr_b1", last_blk[15:0], 16'h1F12);
    // reset mid-COLLECT with a partial byte outstanding
    start_msg();
    chk("perr_cleared", bus.pad_error, 0);
    for (int i = 0; i < 5; i++) send_byte(8'h77, 1'b0);
    send_chunk(2'b10, 1'b0);
    send_chunk(2'b10, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_state", bus.debug_state, 0);
    chk("mid_rst_blk", bus.block_out == '0, 1);
    chk("mid_rst_count", bus.debug_bytecount, 0);
    chk("mid_rst_sready", bus.serial_ready, 0);
    chk("mid_rst_valid", bus.block_valid, 0);
    reset = 1'b1;
    msg.delete();
    msg.push_back(8'hC3);
    build_exp();
    start_msg();
    send_range(0, 1, 1'b0);
    end_pulse();
    wait_done();
    chk("post_rst_b0", last_blk[15:0], 16'h1FC3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
